// File: rtl/front_panel_pkg.sv
// Shared types and jam-byte helpers for the front-panel command sequencer.
package front_panel_pkg;

   localparam logic [7:0] OP_JMP = 8'hC3;
   localparam logic [7:0] OP_NOP = 8'h00;

   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_RST,
      CMD_EXAM,
      CMD_EXNEXT,
      CMD_DEP,
      CMD_DEPNEXT
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_JAM,
      ST_DEP,
      ST_DONE
   } state_e;

   // Number of jam bytes the CPU must consume for a command.
   function automatic logic [1:0] seq_len(input cmd_e cmd);
      logic [1:0] len;
      case (cmd)
         CMD_RST, CMD_EXAM:       len = 2'd3;
         CMD_EXNEXT, CMD_DEPNEXT: len = 2'd1;
         default:                 len = 2'd0;
      endcase
      return len;
   endfunction

   function automatic logic [7:0] seq_byte(input cmd_e       cmd,
                                           input logic [1:0] idx,
                                           input logic [7:0] lo,
                                           input logic [7:0] hi);
      logic [7:0] b;
      b = OP_NOP;
      case (cmd)
         CMD_RST:  b = (idx == 2'd0) ? OP_JMP : 8'h00;
         CMD_EXAM: begin
            case (idx)
               2'd0:    b = OP_JMP;
               2'd1:    b = lo;
               2'd2:    b = hi;
               default: b = OP_NOP;
            endcase
         end
         default:  b = OP_NOP;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/fp_cmd_arb.sv
// Priority encoder for panel pulses plus the command/switch latch captured on accept.
module fp_cmd_arb
   import front_panel_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       exam_p,
   input  logic       exnext_p,
   input  logic       dep_p,
   input  logic       depnext_p,
   input  logic       rst_p,
   input  logic [7:0] sw_lo,
   input  logic [7:0] sw_hi,
   output cmd_e       req_cmd,
   output cmd_e       cmd,
   output logic [7:0] lo,
   output logic [7:0] hi
);

   cmd_e       cmd_q, cmd_d;
   logic [7:0] lo_q, lo_d;
   logic [7:0] hi_q, hi_d;

   // Lower-priority pulses in the same cycle are simply dropped.
   always_comb begin
      req_cmd = CMD_NONE;
      if (en) begin
         if (rst_p)          req_cmd = CMD_RST;
         else if (exam_p)    req_cmd = CMD_EXAM;
         else if (exnext_p)  req_cmd = CMD_EXNEXT;
         else if (dep_p)     req_cmd = CMD_DEP;
         else if (depnext_p) req_cmd = CMD_DEPNEXT;
      end
   end

   always_comb begin
      cmd_d = cmd_q;
      lo_d  = lo_q;
      hi_d  = hi_q;
      if (req_cmd != CMD_NONE) begin
         cmd_d = req_cmd;
         lo_d  = sw_lo;
         hi_d  = sw_hi;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_q <= CMD_NONE;
         lo_q  <= '0;
         hi_q  <= '0;
      end else begin
         cmd_q <= cmd_d;
         lo_q  <= lo_d;
         hi_q  <= hi_d;
      end
   end

   assign cmd = cmd_q;
   assign lo  = lo_q;
   assign hi  = hi_q;

endmodule

// File: rtl/front_panel_seq.sv
// Front-panel sequencer: arbitrates button commands, jams bytes into the CPU and strobes deposits.
module front_panel_seq
   import front_panel_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1023,
   parameter int unsigned TO_W    = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pause,
   input  logic       exam_p,
   input  logic       exnext_p,
   input  logic       dep_p,
   input  logic       depnext_p,
   input  logic       rst_p,
   input  logic [7:0] sw_lo,
   input  logic [7:0] sw_hi,
   input  logic       cpu_rd,
   output logic       jam_en,
   output logic [7:0] jam_data,
   output logic       dep_we,
   output logic [7:0] dep_data,
   output logic       busy,
   output logic       done,
   output logic       err
);

   state_e          state_q, state_d;
   logic [1:0]      idx_q, idx_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            jam_en_q, jam_en_d;
   logic [7:0]      jam_data_q, jam_data_d;
   logic            dep_we_q, dep_we_d;
   logic [7:0]      dep_data_q, dep_data_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   cmd_e            req_cmd;
   cmd_e            cmd;
   logic [7:0]      lat_lo;
   logic [7:0]      lat_hi;

   fp_cmd_arb u_arb (
      .clk       (clk),
      .reset     (reset),
      .en        (pause && (state_q == ST_IDLE)),
      .exam_p    (exam_p),
      .exnext_p  (exnext_p),
      .dep_p     (dep_p),
      .depnext_p (depnext_p),
      .rst_p     (rst_p),
      .sw_lo     (sw_lo),
      .sw_hi     (sw_hi),
      .req_cmd   (req_cmd),
      .cmd       (cmd),
      .lo        (lat_lo),
      .hi        (lat_hi)
   );

   // Outputs are registered, so each state computes the values seen in the next state.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      to_cnt_d   = to_cnt_q;
      jam_en_d   = 1'b0;
      jam_data_d = '0;
      dep_we_d   = 1'b0;
      dep_data_d = '0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;

      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (req_cmd != CMD_NONE) begin
               busy_d   = 1'b1;
               err_d    = 1'b0;
               idx_d    = '0;
               to_cnt_d = '0;
               if (req_cmd == CMD_DEP) begin
                  state_d    = ST_DEP;
                  dep_we_d   = 1'b1;
                  dep_data_d = sw_lo;
               end else begin
                  state_d    = ST_JAM;
                  jam_en_d   = 1'b1;
                  jam_data_d = seq_byte(req_cmd, 2'd0, sw_lo, sw_hi);
               end
            end
         end

         ST_JAM: begin
            if (!pause) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else if (cpu_rd) begin
               to_cnt_d = '0;
               if (idx_q == seq_len(cmd) - 2'd1) begin
                  if (cmd == CMD_DEPNEXT) begin
                     state_d    = ST_DEP;
                     dep_we_d   = 1'b1;
                     dep_data_d = lat_lo;
                  end else begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end
               end else begin
                  idx_d      = idx_q + 2'd1;
                  jam_en_d   = 1'b1;
                  jam_data_d = seq_byte(cmd, idx_q + 2'd1, lat_lo, lat_hi);
               end
            end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               err_d   = 1'b1;
            end else begin
               to_cnt_d   = to_cnt_q + TO_W'(1);
               jam_en_d   = 1'b1;
               jam_data_d = seq_byte(cmd, idx_q, lat_lo, lat_hi);
            end
         end

         ST_DEP: begin
            if (!pause) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         to_cnt_q   <= '0;
         jam_en_q   <= 1'b0;
         jam_data_q <= '0;
         dep_we_q   <= 1'b0;
         dep_data_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         to_cnt_q   <= to_cnt_d;
         jam_en_q   <= jam_en_d;
         jam_data_q <= jam_data_d;
         dep_we_q   <= dep_we_d;
         dep_data_q <= dep_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign jam_en   = jam_en_q;
   assign jam_data = jam_data_q;
   // The strobe is already registered when DEP is entered; pause gates it so a pause drop writes nothing.
   assign dep_we   = dep_we_q && pause;
   assign dep_data = dep_data_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: doc/front_panel_seq.md
Name: front_panel_seq

Overview:
- Single sequencer and arbiter for all front-panel operations: examine, examine-next, deposit, deposit-next and panel reset.
- Takes one-cycle button pulses from the debouncers and accepts one command at a time.
- Drives "jam" bytes onto the CPU data input so the i8080 itself moves its PC, and generates the memory write strobe for deposits.
- Sits between the debouncers and the top-level idata/ram_in muxes. Replaces the five independent per-button latch blocks.

Parameters:
- TIMEOUT, 1023, max clk cycles to wait for the CPU to consume one jam byte before aborting.
- TO_W, 10, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pause  in  1  pause-mode switch; commands are accepted only while it is 1
- exam_p, exnext_p, dep_p, depnext_p, rst_p  in  1 each  single-cycle command pulses
- sw_lo  in  8  data / low-address switches
- sw_hi  in  8  high-address switches
- cpu_rd  in  1  one-cycle pulse: CPU consumed the presented jam byte (CE-qualified read)
- jam_en  out  1  selects jam_data onto CPU idata; also enables CPU ce
- jam_data  out  8  byte presented to the CPU
- dep_we  out  1  one-cycle memory write strobe at the CPU's current address
- dep_data  out  8  write data for deposit
- busy  out  1  a command is in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky timeout flag; cleared by reset or by the next accepted command

Behaviour:
- Reset values: all outputs 0; state IDLE; latches 0.
- States: IDLE, JAM, DEP, DONE.
- IDLE
  - Command accepted when pause=1 and any pulse is present.
  - Simultaneous pulses resolved by priority: rst > exam > exnext > dep > depnext. Lower-priority pulses in the same cycle are dropped.
  - On accept, sw_lo and sw_hi are latched. busy=1 from the next cycle. err is cleared.
  - Pulses arriving while busy=1 or pause=0 are ignored, not queued.
- Jam sequences (byte index 0..n-1):
  - rst: C3 00 00 (JMP 0000)
  - exam: C3 lo hi (JMP hi:lo)
  - exnext: 00 (NOP)
  - depnext: 00, then DEP
  - dep: no jam; goes directly IDLE -> DEP
- JAM
  - jam_en=1 and jam_data=seq[idx], starting the cycle after accept.
  - cpu_rd=1 increments idx the next cycle and reloads the timeout counter to 0.
  - After the last byte is consumed: go to DEP for depnext, else DONE.
  - jam_en drops in the cycle after the last cpu_rd.
- DEP
  - Exactly one cycle with dep_we=1 and dep_data = latched sw_lo; then DONE.
- DONE
  - done=1 for one cycle, busy=0 from the following cycle, then IDLE.
  - A new command may be accepted in the first IDLE cycle.
- Timeout
  - Counter runs in JAM while cpu_rd=0.
  - When it reaches TIMEOUT: err=1, jam_en=0, go to IDLE with no done pulse and no write.
- Pause dropped mid-command (pause=0 in JAM or DEP): abort to IDLE next cycle; no dep_we, no done.
- Reset mid-command: all state returns to reset values at the next edge; jam_en and dep_we must be 0 in that cycle.
- cpu_rd outside JAM is ignored.
- Latency: pulse at edge t gives jam_en=1 at t+1. For dep, dep_we=1 at t+1 and done at t+2.

Decomposition:
- Shared package front_panel_pkg holds:
  - opcode constants OP_JMP=8'hC3, OP_NOP=8'h00
  - command enum CMD_NONE, CMD_RST, CMD_EXAM, CMD_EXNEXT, CMD_DEP, CMD_DEPNEXT
  - state enum
- One sub-module, fp_cmd_arb: priority encoder plus switch latch producing {cmd, lo, hi}.
- The FSM, byte sequencer and timeout counter stay in front_panel_seq.

Test Plan:
- pause=1, sw_hi=12, sw_lo=34, exam_p pulse; cpu_rd on three later cycles -> jam_data C3, 34, 12 in order; done one cycle after DONE entry; no dep_we.
- depnext_p with sw_lo=A5; one cpu_rd -> jam 00, then dep_we=1 for exactly one cycle with dep_data=A5, then done.
- exam_p and dep_p in the same cycle -> examine executes; no dep_we during the whole sequence.
- exnext_p with cpu_rd held 0 and TIMEOUT=8 -> jam_en drops after 8 cycles; err=1; no done. A subsequent dep_p clears err.
- exam_p then pause=0 after the first cpu_rd -> abort; jam_en=0 next cycle; no done. Also: pulses with pause=0 produce no response.
- reset asserted during JAM byte 1 -> all outputs 0 next cycle. rst_p afterwards -> C3 00 00.
